// File: rtl/morse_rx_timed.sv
// Morse receiver: one counter times presses and gaps, emits character and word-gap strobes.
// Optional glitch filter enabled by defining MORSE_RX_GLITCH_FILTER_EN.
module morse_rx_timed #(
    parameter int MAX_SYMS      = 6,
    parameter int CNT_W         = 28,
    parameter int DASH_CYC      = 25_000_000,
    parameter int INTER_CYC     = 50_000_000,
    parameter int WORD_CYC      = 150_000_000,
    parameter int MIN_PRESS_CYC = 1_000_000
) (
    input  logic                            clk_100MHz,
    input  logic                            reset,
    input  logic                            user_btn,
    output logic [MAX_SYMS-1:0]             char_data,
    output logic [$clog2(MAX_SYMS+1)-1:0]   char_len,
    output logic                            char_valid,
    output logic                            char_err,
    output logic                            word_valid,
    output logic                            busy
);

    localparam int LEN_W = $clog2(MAX_SYMS + 1);

`ifdef MORSE_RX_GLITCH_FILTER_EN
    localparam int KEEP_MIN = MIN_PRESS_CYC;
`else
    // Every press holds cnt >= 1, so a minimum of 1 keeps every press.
    localparam int KEEP_MIN = 1 + 0 * MIN_PRESS_CYC;
`endif

    localparam logic [CNT_W-1:0] DASH_C  = CNT_W'(DASH_CYC);
    localparam logic [CNT_W-1:0] INTER_C = CNT_W'(INTER_CYC - 1);
    localparam logic [CNT_W-1:0] WORD_C  = CNT_W'(WORD_CYC - 1);
    localparam logic [CNT_W-1:0] KEEP_C  = CNT_W'(KEEP_MIN);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [LEN_W-1:0] FULL_L  = LEN_W'(MAX_SYMS);

    typedef enum logic [1:0] {IDLE, PRESS, GAP, WGAP} state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [MAX_SYMS-1:0] sym, sym_n;
    logic [LEN_W-1:0]    len, len_n;
    logic                ovf, ovf_n;
    logic                char_fire, word_fire;
    logic                is_dash, keep;

    assign busy = (state != IDLE);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        sym_n     = sym;
        len_n     = len;
        ovf_n     = ovf;
        char_fire = 1'b0;
        word_fire = 1'b0;
        is_dash   = (cnt >= DASH_C);
        keep      = (cnt >= KEEP_C);
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (user_btn) begin
                    state_n = PRESS;
                    cnt_n   = ONE_C;
                end
            end
            PRESS: begin
                if (user_btn) begin
                    if (cnt < DASH_C) cnt_n = cnt + ONE_C;
                end else if (keep) begin
                    if (len == FULL_L) begin
                        ovf_n = 1'b1;
                    end else begin
                        for (int i = 0; i < MAX_SYMS; i++)
                            if (len == LEN_W'(i)) sym_n[i] = is_dash;
                        len_n = len + LEN_W'(1);
                    end
                    state_n = GAP;
                    cnt_n   = ONE_C;
                end else if (len != '0 || ovf) begin
                    state_n = GAP;
                    cnt_n   = ONE_C;
                end else begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            GAP: begin
                if (user_btn) begin
                    state_n = PRESS;
                    cnt_n   = ONE_C;
                end else begin
                    cnt_n = cnt + ONE_C;
                    // This low sample is the INTER_CYC-th since release.
                    if (cnt == INTER_C) begin
                        char_fire = 1'b1;
                        sym_n     = '0;
                        len_n     = '0;
                        ovf_n     = 1'b0;
                        state_n   = WGAP;
                    end
                end
            end
            WGAP: begin
                if (user_btn) begin
                    state_n = PRESS;
                    cnt_n   = ONE_C;
                end else if (cnt == WORD_C) begin
                    word_fire = 1'b1;
                    state_n   = IDLE;
                    cnt_n     = '0;
                end else begin
                    cnt_n = cnt + ONE_C;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            sym        <= '0;
            len        <= '0;
            ovf        <= 1'b0;
            char_data  <= '0;
            char_len   <= '0;
            char_err   <= 1'b0;
            char_valid <= 1'b0;
            word_valid <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            sym        <= sym_n;
            len        <= len_n;
            ovf        <= ovf_n;
            char_valid <= char_fire;
            word_valid <= word_fire;
            if (char_fire) begin
                char_data <= sym;
                char_len  <= len;
                char_err  <= ovf;
            end
        end
    end

endmodule
